// File: rtl/cache_ctrl_nway.sv
// N-way set-associative cache controller: lookup, dirty writeback, line fill, memory stall timeout.
// Optional saturating hit/miss/writeback counters when CACHE_PERF_CNT_EN is defined.
module cache_ctrl_nway #(
    parameter int WAYS        = 4,
    parameter int LINE_BEATS  = 8,
    parameter int MEM_TIMEOUT = 255
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          cpu_read,
    input  logic                          cpu_write,
    input  logic [WAYS-1:0]               hit_way,
    input  logic [WAYS-1:0]               is_valid,
    input  logic [WAYS-1:0]               is_dirty,
    input  logic [$clog2(WAYS)-1:0]       victim_way,
    input  logic                          mem_ready,
    input  logic                          mem_beat_valid,
    output logic                          cpu_mem_valid,
    output logic                          cpu_busy,
    output logic [$clog2(WAYS)-1:0]       way_sel,
    output logic [$clog2(LINE_BEATS)-1:0] beat_idx,
    output logic                          load_data_word,
    output logic                          load_data_line,
    output logic                          load_tag,
    output logic                          meta_write,
    output logic                          meta_valid,
    output logic                          meta_dirty,
    output logic                          lru_touch,
    output logic                          data_in_select,
    output logic                          mem_read,
    output logic                          mem_write,
    output logic                          error
`ifdef CACHE_PERF_CNT_EN
    ,
    output logic [31:0]                   hit_cnt,
    output logic [31:0]                   miss_cnt,
    output logic [31:0]                   wb_cnt
`endif
);

    localparam int WW = $clog2(WAYS);
    localparam int BW = $clog2(LINE_BEATS);

    // state      | meaning
    // IDLE       | waiting for a CPU request
    // LOOKUP     | tag compare; hit completes, miss picks victim
    // WB_REQ     | writeback request held until accepted
    // WB_BEATS   | victim line streamed out to memory
    // FILL_REQ   | fill request held until accepted
    // FILL_BEATS | line streamed in, then tag/meta written and lookup replayed
    // ERROR      | one-cycle error pulse (multi-hit or memory timeout)
    typedef enum logic [2:0] {
        S_IDLE, S_LOOKUP, S_WB_REQ, S_WB_BEATS, S_FILL_REQ, S_FILL_BEATS, S_ERROR
    } state_t;

    state_t          state_q, state_d;
    logic            op_wr_q, op_wr_d;
    logic            replay_q, replay_d;
    logic [WW-1:0]   way_q, way_d;
    logic [BW-1:0]   beat_q, beat_d;
    logic [15:0]     tmo_q, tmo_d;

    logic [WAYS-1:0] v;
    logic            v_any, v_multi;
    logic [WW-1:0]   v_idx;
    logic            last_beat, mem_state, progress;

    assign v         = hit_way & is_valid;
    assign v_any     = |v;
    assign v_multi   = (v & (v - WAYS'(1))) != '0;
    assign last_beat = beat_q == BW'(LINE_BEATS - 1);
    assign mem_state = (state_q == S_WB_REQ) || (state_q == S_WB_BEATS) ||
                       (state_q == S_FILL_REQ) || (state_q == S_FILL_BEATS);

    always_comb begin
        v_idx = '0;
        for (int i = 0; i < WAYS; i++) begin
            if (v[i]) v_idx = WW'(i);
        end
    end

    always_comb begin
        state_d        = state_q;
        op_wr_d        = op_wr_q;
        replay_d       = replay_q;
        way_d          = way_q;
        beat_d         = beat_q;
        tmo_d          = '0;
        progress       = 1'b0;
        cpu_mem_valid  = 1'b0;
        load_data_word = 1'b0;
        load_data_line = 1'b0;
        load_tag       = 1'b0;
        meta_write     = 1'b0;
        meta_valid     = 1'b0;
        meta_dirty     = 1'b0;
        lru_touch      = 1'b0;
        data_in_select = 1'b0;
        mem_read       = 1'b0;
        mem_write      = 1'b0;
        error          = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (cpu_write || cpu_read) begin
                    op_wr_d  = cpu_write;
                    replay_d = 1'b0;
                    state_d  = S_LOOKUP;
                    // Pre-load the hit way so the registered way_sel is valid in LOOKUP.
                    if (v_any && !v_multi) way_d = v_idx;
                end
            end
            S_LOOKUP: begin
                replay_d = 1'b0;
                if (v_multi) begin
                    state_d = S_ERROR;
                end else if (v_any) begin
                    way_d         = v_idx;
                    lru_touch     = 1'b1;
                    cpu_mem_valid = 1'b1;
                    if (op_wr_q) begin
                        load_data_word = 1'b1;
                        meta_write     = 1'b1;
                        meta_valid     = 1'b1;
                        meta_dirty     = 1'b1;
                    end
                    state_d = S_IDLE;
                end else begin
                    way_d   = victim_way;
                    beat_d  = '0;
                    state_d = (is_valid[victim_way] && is_dirty[victim_way]) ? S_WB_REQ : S_FILL_REQ;
                end
            end
            S_WB_REQ: begin
                mem_write = 1'b1;
                if (mem_ready) begin
                    progress = 1'b1;
                    beat_d   = '0;
                    state_d  = S_WB_BEATS;
                end
            end
            S_WB_BEATS: begin
                if (mem_beat_valid) begin
                    progress = 1'b1;
                    if (last_beat) begin
                        beat_d  = '0;
                        state_d = S_FILL_REQ;
                    end else begin
                        beat_d = beat_q + BW'(1);
                    end
                end
            end
            S_FILL_REQ: begin
                mem_read = 1'b1;
                if (mem_ready) begin
                    progress = 1'b1;
                    beat_d   = '0;
                    state_d  = S_FILL_BEATS;
                end
            end
            S_FILL_BEATS: begin
                if (mem_beat_valid) begin
                    progress       = 1'b1;
                    load_data_line = 1'b1;
                    data_in_select = 1'b1;
                    if (last_beat) begin
                        load_tag   = 1'b1;
                        meta_write = 1'b1;
                        meta_valid = 1'b1;
                        beat_d     = '0;
                        replay_d   = 1'b1;
                        state_d    = S_LOOKUP;
                    end else begin
                        beat_d = beat_q + BW'(1);
                    end
                end
            end
            S_ERROR: begin
                error   = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // tmo_q counts consecutive stalled cycles; the MEM_TIMEOUT-th stall aborts.
        if (mem_state && !progress) begin
            if (tmo_q == 16'(MEM_TIMEOUT - 1)) begin
                state_d = S_ERROR;
            end else begin
                tmo_d = tmo_q + 16'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            op_wr_q  <= 1'b0;
            replay_q <= 1'b0;
            way_q    <= '0;
            beat_q   <= '0;
            tmo_q    <= '0;
        end else begin
            state_q  <= state_d;
            op_wr_q  <= op_wr_d;
            replay_q <= replay_d;
            way_q    <= way_d;
            beat_q   <= beat_d;
            tmo_q    <= tmo_d;
        end
    end

    assign cpu_busy = state_q != S_IDLE;
    assign way_sel  = way_q;
    assign beat_idx = beat_q;

`ifdef CACHE_PERF_CNT_EN
    logic [31:0] hit_cnt_q, miss_cnt_q, wb_cnt_q;
    logic        hit_inc, miss_inc, wb_inc;

    assign hit_inc  = (state_q == S_LOOKUP) && v_any && !v_multi && !replay_q;
    assign miss_inc = (state_q == S_LOOKUP) && !v_any;
    assign wb_inc   = (state_q == S_WB_REQ) && mem_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
            wb_cnt_q   <= '0;
        end else begin
            if (hit_inc && hit_cnt_q != '1)   hit_cnt_q  <= hit_cnt_q + 32'd1;
            if (miss_inc && miss_cnt_q != '1) miss_cnt_q <= miss_cnt_q + 32'd1;
            if (wb_inc && wb_cnt_q != '1)     wb_cnt_q   <= wb_cnt_q + 32'd1;
        end
    end

    assign hit_cnt  = hit_cnt_q;
    assign miss_cnt = miss_cnt_q;
    assign wb_cnt   = wb_cnt_q;
`endif

endmodule
